// File: rtl/spi_pkg.sv
// Shared definitions for the SPI register-file peripheral: FSM encoding,
// frame layout helpers and reset defaults.
package spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // R/nW is the first bit on the wire, i.e. the MSB of the header
  localparam int   RNW_POS = 0;
  localparam logic RST_VAL = 1'b0;

  function automatic int frame_w(input int addr_w, input int data_w);
    return 1 + addr_w + data_w;
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchroniser for an asynchronous pin, with registered-history
// rise/fall detection on the synchronised level.
module sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], async_i};
    prev_d = sync_q[STAGES-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign level_o = sync_q[STAGES-1];
  assign rise_o  = level_o & ~prev_q;
  assign fall_o  = ~level_o & prev_q;

endmodule

// File: rtl/spi_regfile_rw.sv
// SPI mode-0 peripheral with a read/write control-register file. Writes
// commit on nCS rise; reads stream reg[addr] out on CIPO during the data phase.
module spi_regfile_rw
  import spi_pkg::*;
#(
  parameter int NUM_REGS    = 5,
  parameter int ADDR_W      = 7,
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         SCLK,
  input  logic                         nCS,
  input  logic                         COPI,
  output logic                         CIPO,
  output logic                         cipo_oe,
  output logic [NUM_REGS*DATA_W-1:0]   regs_out,
  output logic                         wr_strobe,
  output logic [ADDR_W-1:0]            wr_addr,
  output logic                         frame_err
);

  localparam int FRAME_W = frame_w(ADDR_W, DATA_W);
  localparam int HDR_W   = 1 + ADDR_W;
  localparam int RX_W    = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int CNT_W   = $clog2(FRAME_W + 2);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(FRAME_W + 1);
  localparam logic [CNT_W-1:0] HDR_LAST  = CNT_W'(HDR_W - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(FRAME_W - 1);

  logic sclk_lvl_unused, sclk_rise, sclk_fall;
  logic cs_lvl, cs_rise, cs_fall;
  logic copi_lvl, copi_rise_unused, copi_fall_unused;

  // Idle levels at reset so a frame cut by reset never looks complete
  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst(rst), .async_i(SCLK),
    .level_o(sclk_lvl_unused), .rise_o(sclk_rise), .fall_o(sclk_fall));
  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rst(rst), .async_i(nCS),
    .level_o(cs_lvl), .rise_o(cs_rise), .fall_o(cs_fall));
  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_copi (
    .clk(clk), .rst(rst), .async_i(COPI),
    .level_o(copi_lvl), .rise_o(copi_rise_unused), .fall_o(copi_fall_unused));

  state_e state_q, state_d;

  logic [CNT_W-1:0]                    cnt_q, cnt_d;
  logic [RX_W-1:0]                     rx_q, rx_d;
  logic [DATA_W-1:0]                   tx_q, tx_d;
  logic                                cmd_q, cmd_d;
  logic [ADDR_W-1:0]                   addr_q, addr_d;
  logic                                ovf_q, ovf_d;
  logic                                cipo_q, cipo_d;
  logic [NUM_REGS-1:0][DATA_W-1:0]     regs_q, regs_d;
  logic                                wr_strobe_q, wr_strobe_d;
  logic [ADDR_W-1:0]                   wr_addr_q, wr_addr_d;
  logic                                frame_err_q, frame_err_d;

  logic [HDR_W-1:0]  hdr;
  logic [DATA_W-1:0] rd_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (cs_rise) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (cs_fall) state_d = ST_ADDR;
        ST_ADDR: if (sclk_rise && cnt_q == HDR_LAST) state_d = ST_DATA;
        ST_DATA: if (sclk_rise && cnt_q == DATA_LAST) state_d = ST_DONE;
        default: state_d = state_q;
      endcase
    end
  end

  // Header as it stands including the bit arriving on this rise
  assign hdr = {rx_q[ADDR_W-1:0], copi_lvl};

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (hdr[ADDR_W-1:0] == ADDR_W'(i)) rd_data = regs_q[i];
  end

  always_comb begin
    cnt_d       = cnt_q;
    rx_d        = rx_q;
    tx_d        = tx_q;
    cmd_d       = cmd_q;
    addr_d      = addr_q;
    ovf_d       = ovf_q;
    cipo_d      = cipo_q;
    regs_d      = regs_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    frame_err_d = 1'b0;
    if (cs_rise) begin
      cipo_d = 1'b0;
      if (state_q != ST_DONE || ovf_q) begin
        frame_err_d = 1'b1;
      end else if (cmd_q) begin
        // Out-of-range addresses match no register and are dropped
        for (int j = 0; j < NUM_REGS; j++) begin
          if (addr_q == ADDR_W'(j)) begin
            regs_d[j]   = rx_q[DATA_W-1:0];
            wr_strobe_d = 1'b1;
            wr_addr_d   = addr_q;
          end
        end
      end
    end else if (cs_fall && state_q == ST_IDLE) begin
      cnt_d = '0;
      rx_d  = '0;
      tx_d  = '0;
      ovf_d = 1'b0;
    end else if (state_q != ST_IDLE) begin
      if (sclk_rise) begin
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
        if (state_q == ST_DONE) ovf_d = 1'b1;
        else                    rx_d  = {rx_q[RX_W-2:0], copi_lvl};
        if (state_q == ST_ADDR && cnt_q == HDR_LAST) begin
          cmd_d  = hdr[HDR_W-1-RNW_POS];
          addr_d = hdr[ADDR_W-1:0];
          tx_d   = rd_data;
        end
      end else if (sclk_fall && state_q == ST_DATA) begin
        cipo_d = tx_q[DATA_W-1];
        tx_d   = {tx_q[DATA_W-2:0], 1'b0};
      end
      if (state_q != ST_DATA) cipo_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      rx_q        <= '0;
      tx_q        <= '0;
      cmd_q       <= RST_VAL;
      addr_q      <= '0;
      ovf_q       <= 1'b0;
      cipo_q      <= RST_VAL;
      regs_q      <= '0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      frame_err_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      cmd_q       <= cmd_d;
      addr_q      <= addr_d;
      ovf_q       <= ovf_d;
      cipo_q      <= cipo_d;
      regs_q      <= regs_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign CIPO      = cipo_q;
  assign cipo_oe   = ~cs_lvl;
  assign regs_out  = regs_q;
  assign wr_strobe = wr_strobe_q;
  assign wr_addr   = wr_addr_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_regfile_rw.sv
// Directed bench: default build (5x8) and a 16x16 build share SCLK/COPI,
// each with its own nCS. SCLK runs at clk/8.
module tb_spi_regfile_rw;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic SCLK = 1'b0;
  logic COPI = 1'b0;
  logic nCS0 = 1'b1, nCS1 = 1'b1;

  logic          CIPO0, cipo_oe0, wr_strobe0, frame_err0;
  logic [39:0]   regs_out0;
  logic [6:0]    wr_addr0;
  logic          CIPO1, cipo_oe1, wr_strobe1, frame_err1;
  logic [255:0]  regs_out1;
  logic [6:0]    wr_addr1;

  int n_chk = 0, n_fail = 0;
  int stb0 = 0, err0 = 0, stb1 = 0, err1 = 0;

  always #5 clk = ~clk;

  spi_regfile_rw u_dut0 (
    .clk(clk), .rst(rst), .SCLK(SCLK), .nCS(nCS0), .COPI(COPI),
    .CIPO(CIPO0), .cipo_oe(cipo_oe0), .regs_out(regs_out0),
    .wr_strobe(wr_strobe0), .wr_addr(wr_addr0), .frame_err(frame_err0));

  spi_regfile_rw #(.NUM_REGS(16), .ADDR_W(7), .DATA_W(16), .SYNC_STAGES(2)) u_dut1 (
    .clk(clk), .rst(rst), .SCLK(SCLK), .nCS(nCS1), .COPI(COPI),
    .CIPO(CIPO1), .cipo_oe(cipo_oe1), .regs_out(regs_out1),
    .wr_strobe(wr_strobe1), .wr_addr(wr_addr1), .frame_err(frame_err1));

  // Pulse-cycle counters; a 1-cycle pulse adds exactly one
  always @(negedge clk) begin
    if (wr_strobe0) stb0 <= stb0 + 1;
    if (frame_err0) err0 <= err0 + 1;
    if (wr_strobe1) stb1 <= stb1 + 1;
    if (frame_err1) err1 <= err1 + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cs_low(input int which);
    @(negedge clk);
    if (which == 0) nCS0 = 1'b0; else nCS1 = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic cs_high(input int which);
    repeat (4) @(negedge clk);
    if (which == 0) nCS0 = 1'b1; else nCS1 = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic shift_bit(input int which, input logic b, output logic so);
    COPI = b;
    repeat (4) @(negedge clk);
    so = (which == 0) ? CIPO0 : CIPO1;
    SCLK = 1'b1;
    repeat (4) @(negedge clk);
    SCLK = 1'b0;
  endtask

  task automatic frame(input int which, input int nbits, input logic [31:0] bits,
                       output logic [31:0] rx, output int nstb, output int nerr);
    int s0, e0;
    logic so;
    s0 = (which == 0) ? stb0 : stb1;
    e0 = (which == 0) ? err0 : err1;
    rx = '0;
    cs_low(which);
    for (int i = nbits - 1; i >= 0; i--) begin
      shift_bit(which, bits[i], so);
      rx = {rx[30:0], so};
    end
    cs_high(which);
    nstb = ((which == 0) ? stb0 : stb1) - s0;
    nerr = ((which == 0) ? err0 : err1) - e0;
  endtask

  initial begin
    logic [31:0] rx;
    logic [15:0] wbits;
    logic        so;
    int nstb, nerr, s0, e0;

    repeat (3) @(negedge clk);
    chk("rst_regs0", regs_out0, 0);
    chk("rst_cipo0", CIPO0, 0);
    chk("rst_oe0", cipo_oe0, 0);
    chk("rst_strobe0", wr_strobe0, 0);
    chk("rst_waddr0", wr_addr0, 0);
    chk("rst_ferr0", frame_err0, 0);
    chk("rst_regs1_lo", regs_out1[63:0], 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // nCS pulse with no clocks: oe while selected, error on release
    e0 = err0;
    cs_low(0);
    chk("oe_selected", cipo_oe0, 1);
    cs_high(0);
    chk("glitch_ferr", err0 - e0, 1);
    chk("oe_released", cipo_oe0, 0);

    frame(0, 16, 32'h80F0, rx, nstb, nerr);
    chk("w0_strobe", nstb, 1);
    chk("w0_ferr", nerr, 0);
    chk("w0_reg", regs_out0[7:0], 8'hF0);
    chk("w0_waddr", wr_addr0, 0);

    frame(0, 16, 32'h8480, rx, nstb, nerr);
    chk("w4_strobe", nstb, 1);
    chk("w4_regs", regs_out0, 40'h80_00_00_00_F0);
    chk("w4_waddr", wr_addr0, 4);

    frame(0, 16, 32'h0400, rx, nstb, nerr);
    chk("r4_cipo", rx[15:0], 16'h0080);
    chk("r4_strobe", nstb, 0);
    chk("r4_ferr", nerr, 0);
    chk("r4_regs", regs_out0, 40'h80_00_00_00_F0);

    frame(0, 16, 32'h9055, rx, nstb, nerr);
    chk("woor_strobe", nstb, 0);
    chk("woor_ferr", nerr, 0);
    chk("woor_regs", regs_out0, 40'h80_00_00_00_F0);
    chk("woor_waddr", wr_addr0, 4);

    frame(0, 16, 32'h1000, rx, nstb, nerr);
    chk("roor_cipo", rx[15:0], 0);

    frame(0, 12, 32'h815, rx, nstb, nerr);
    chk("short_ferr", nerr, 1);
    chk("short_strobe", nstb, 0);
    frame(0, 17, 32'h103FF, rx, nstb, nerr);
    chk("long_ferr", nerr, 1);
    chk("long_strobe", nstb, 0);
    chk("badlen_reg1", regs_out0[15:8], 0);

    // Reset 9 bits into a write of 0xAA to addr 2
    wbits = 16'h82AA;
    s0 = stb0;
    cs_low(0);
    for (int i = 15; i >= 7; i--) shift_bit(0, wbits[i], so);
    rst = 1'b1;
    #1;
    chk("midrst_regs", regs_out0, 0);
    chk("midrst_cipo", CIPO0, 0);
    chk("midrst_oe", cipo_oe0, 0);
    chk("midrst_waddr", wr_addr0, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 6; i >= 0; i--) shift_bit(0, wbits[i], so);
    cs_high(0);
    chk("midrst_nocommit", stb0 - s0, 0);
    chk("midrst_regs_after", regs_out0, 0);

    frame(0, 16, 32'h82AA, rx, nstb, nerr);
    chk("postrst_strobe", nstb, 1);
    chk("postrst_regs", regs_out0, 40'h00_00_AA_00_00);
    chk("postrst_waddr", wr_addr0, 2);

    frame(1, 24, 32'h8FBEEF, rx, nstb, nerr);
    chk("w16_strobe", nstb, 1);
    chk("w16_reg15", regs_out1[255:240], 16'hBEEF);
    chk("w16_waddr", wr_addr1, 15);
    chk("w16_others", regs_out1[63:0], 0);
    frame(1, 24, 32'h0F0000, rx, nstb, nerr);
    chk("r16_cipo", rx[23:0], 24'h00BEEF);
    chk("r16_strobe", nstb, 0);
    chk("dut0_untouched", regs_out0, 40'h00_00_AA_00_00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
